// File: rtl/lm_sm_sequencer.sv
// Load-multiple / store-multiple sequencer for the memory-access stage.
// Walks the register mask lowest bit first, issuing one memory beat per cycle while stalling upstream.
module lm_sm_sequencer #(
   parameter int ADDR_W = 16,
   parameter int MASK_W = 8,
   parameter int IDX_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              is_store_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [MASK_W-1:0] reg_mask_i,
   input  logic              flush_i,
   output logic              busy_o,
   output logic              stall_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              addr_sel_o,
   output logic              mem_we_o,
   output logic [IDX_W-1:0]  st_reg_idx_o,
   output logic              rf_we_o,
   output logic [IDX_W-1:0]  rf_wr_idx_o,
   output logic              done_o,
   output logic [IDX_W:0]    beat_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [MASK_W-1:0] mask_q;
   logic              store_q;
   logic [IDX_W:0]    cnt_q;

   logic [IDX_W-1:0]  idx;
   logic [MASK_W-1:0] mask_d;

   // Priority encoder: scanning downward lets the lowest set bit win.
   // NOTE: idx gets a default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      idx = '0;
      for (int i = MASK_W - 1; i >= 0; i--) begin
         if (mask_q[i]) idx = IDX_W'(i);
      end
   end

   // Clearing the lowest set bit is the same as removing bit idx.
   assign mask_d = mask_q & (mask_q - MASK_W'(1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         mask_q  <= '0;
         store_q <= 1'b0;
         cnt_q   <= '0;
      end else if (flush_i) begin
         state_q <= S_IDLE;
         mask_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  addr_q  <= base_addr_i;
                  mask_q  <= reg_mask_i;
                  store_q <= is_store_i;
                  cnt_q   <= '0;
                  state_q <= (reg_mask_i != '0) ? S_XFER : S_DONE;
               end
            end
            S_XFER: begin
               mask_q  <= mask_d;
               addr_q  <= addr_q + ADDR_W'(1);
               cnt_q   <= cnt_q + (IDX_W + 1)'(1);
               state_q <= (mask_d == '0) ? S_DONE : S_XFER;
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   logic in_xfer;
   assign in_xfer = (state_q == S_XFER);

   // Write enables are gated by flush so a squashed beat never commits.
   always_comb begin
      busy_o       = (state_q != S_IDLE);
      stall_o      = in_xfer | ((state_q == S_IDLE) & start_i & ~flush_i);
      mem_addr_o   = addr_q;
      addr_sel_o   = in_xfer;
      mem_we_o     = in_xfer & store_q & ~flush_i;
      st_reg_idx_o = (in_xfer & store_q) ? idx : '0;
      rf_we_o      = in_xfer & ~store_q & ~flush_i;
      rf_wr_idx_o  = (in_xfer & ~store_q) ? idx : '0;
      done_o       = (state_q == S_DONE) & ~flush_i;
      beat_cnt_o   = cnt_q;
   end

endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
- Multi-cycle controller for load-multiple (LM) and store-multiple (SM) in the memory-access stage.
- Captures the base address and 8-bit register mask of an LM/SM instruction.
- Then steps the data memory one word per cycle, lowest-numbered register first, and stalls the upstream pipeline until the transfer is finished.
- Drives the memory read/write address select, memory write enable, store-data register index and register-file write-back index for each beat.

Parameters:
ADDR_W, 16, width of the memory address and base address
MASK_W, 8, number of registers covered by the mask (R0..R7)
IDX_W, 3, width of the register index; must equal log2(MASK_W)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  LM/SM instruction valid in the memory stage this cycle
is_store  input  1  1 = SM, 0 = LM; sampled with start
base_addr  input  ADDR_W  starting memory address (register A contents); sampled with start
reg_mask  input  MASK_W  register list (IR[7:0]); bit i set = transfer Ri; sampled with start
flush  input  1  branch/exception squash; aborts any sequence
busy  output  1  high while in the XFER or DONE state
stall  output  1  freeze the upstream pipeline registers
mem_addr  output  ADDR_W  address for this beat; drives both the read and the write address
addr_sel  output  1  1 = memory uses mem_addr; 0 = normal pipeline address path
mem_we  output  1  data-memory write enable (SM beats only)
st_reg_idx  output  IDX_W  register-file read index supplying store data (SM)
rf_we  output  1  register-file write enable for a load beat (LM)
rf_wr_idx  output  IDX_W  destination register for the load beat (LM)
done  output  1  one-cycle pulse when a sequence completes normally
beat_cnt  output  IDX_W+1  beats issued so far in the current sequence

Behaviour:
- State machine with states IDLE, XFER and DONE, plus registers addr_q, mask_q, store_q and cnt_q.
- Reset (reset=0, asynchronous):
  - state=IDLE; addr_q=0; mask_q=0; store_q=0; cnt_q=0.
  - All outputs 0: busy, stall, addr_sel, mem_we, rf_we, done, mem_addr, indices, beat_cnt.
  - Reset in mid-sequence abandons it immediately; no further writes occur.
- IDLE:
  - On start=1 and flush=0: addr_q<=base_addr, mask_q<=reg_mask, store_q<=is_store, cnt_q<=0.
  - Next state is XFER if reg_mask!=0, otherwise DONE.
  - stall=start&~flush (combinational) so the instruction is held the same cycle.
  - All other outputs are 0.
- XFER, one beat per cycle:
  - idx is the lowest set bit of mask_q (priority encoder, bit 0 highest priority).
  - mem_addr=addr_q, addr_sel=1, stall=1, busy=1.
  - SM beat: mem_we=1 and st_reg_idx=idx.
  - LM beat: rf_we=1 and rf_wr_idx=idx; data is the combinational memory read of the same cycle.
  - Unused index outputs are 0.
  - At the edge: clear bit idx in mask_q; addr_q<=addr_q+1 (wraps 16'hFFFF to 16'h0000, no error); cnt_q<=cnt_q+1.
  - If the updated mask is 0, go to DONE; otherwise stay in XFER.
- DONE:
  - done=1 and busy=1 for exactly one cycle; stall=0, so the pipeline advances this cycle; mem_we=0 and rf_we=0.
  - Next state is IDLE; a start in DONE is ignored.
  - The upstream stage does not present a new LM/SM before seeing stall=0.
- Latency:
  - With N = popcount(reg_mask), start to done is N+1 cycles.
  - stall is high for N+1 cycles: the start cycle plus N beats.
  - An empty mask gives done one cycle after start with no memory or register-file activity.
- beat_cnt = cnt_q: holds its final value N through DONE and is cleared on the next accepted start.
- flush:
  - Any state: at the next edge state<=IDLE and mask_q<=0; done is not pulsed.
  - In the flush cycle itself, mem_we and rf_we are forced to 0 (combinational gating) so a squashed beat writes nothing.
  - start together with flush in IDLE is ignored.
- mem_addr holds addr_q in every state; it is zero after reset. It is only meaningful while addr_sel=1.

Test Plan:
- SM, base_addr=16'h0040, reg_mask=8'b1010_0101 -> 4 beats: (0040,R0), (0041,R2), (0042,R5), (0043,R7) with mem_we=1; done pulses at cycle 5; stall high for cycles 0-4; beat_cnt=4.
- LM, base_addr=16'h0100, reg_mask=8'hFF -> rf_wr_idx 0..7 at addresses 0100..0107 with rf_we=1 each cycle; mem_we=0 throughout; done at cycle 9.
- start with reg_mask=8'h00 -> no mem_we or rf_we; done=1 at cycle 1; stall=1 only in cycle 0.
- SM, base_addr=16'hFFFE, reg_mask=8'b0000_0111 -> beat addresses FFFE, FFFF, 0000; done at cycle 4.
- LM with reg_mask=8'hFF, flush asserted during the 3rd beat -> rf_we=0 in that cycle; IDLE next cycle; no done pulse; exactly 2 register writes total.
- reset driven low during the 2nd beat of an SM -> all outputs 0 immediately (before the clock edge); a subsequent start with reg_mask=8'h01 runs a clean 1-beat sequence.
